tf_step_monitor: RTL and testbench



---
 rtl/tf_step_mon_pkg.sv | 24 ++
 rtl/tf_settle_detect.sv | 103 ++++++++++
 rtl/tf_step_monitor.sv | 136 +++++++++++++
 tb/tb_tf_step_monitor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tf_step_mon_pkg.sv
// Shared types and width helpers for the tf_step_monitor step-response block.
//
// Contents:
//   state_e    - run-control states (idle, driving the step, results held)
//   err_width  - width of the signed error / magnitude datapath (one bit wider
//                than the sample word so v_out - target can never overflow)
//   cnt_width  - width needed to hold a cycle count in the range 0..TIMEOUT
package tf_step_mon_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic int unsigned err_width(input int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/tf_settle_detect.sv
// Per-channel settle detector for tf_step_monitor.
//
// Compares one filter output against its target every DRIVE cycle, counts
// consecutive in-band samples and latches pass / settle time once HOLD samples
// in a row are in band. Channels still unsettled when the run finishes report
// settle_cycles = TIMEOUT.
//
// Optional feature (macro TF_STEP_MON_OVERSHOOT_EN): peak_err records the signed
// error of largest magnitude seen during DRIVE (first occurrence wins on ties).
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   clear          - run start accepted: clear results and counters
//   active         - monitor is in DRIVE this cycle
//   finish         - the run ends after this cycle
//   t              - DRIVE cycle index
//   v_out, target  - signed filter output and latched target
//   tol            - latched unsigned band half-width
//   pass_now       - passed, including a latch happening this cycle
//   pass           - registered settled flag
//   settle_cycles  - registered settle time
//   peak_err       - (optional) signed peak error
module tf_settle_detect
    import tf_step_mon_pkg::*;
#(
    parameter int unsigned WIDTH   = 18,
    parameter int unsigned HOLD    = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CW      = cnt_width(TIMEOUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    active,
    input  logic                    finish,
    input  logic [CW-1:0]           t,
    input  logic signed [WIDTH-1:0] v_out,
    input  logic signed [WIDTH-1:0] target,
    input  logic [WIDTH-1:0]        tol,
    output logic                    pass_now,
    output logic                    pass,
    output logic [CW-1:0]           settle_cycles
`ifdef TF_STEP_MON_OVERSHOOT_EN
    ,
    output logic signed [WIDTH:0]   peak_err
`endif
);

    localparam int unsigned EW = err_width(WIDTH);
    // Run counter only has to reach HOLD-1; the HOLD-th sample is the latch itself.
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic signed [EW-1:0] err;
    logic [EW-1:0]        err_mag;
    logic                 in_band;
    logic                 hit;
    logic [HW-1:0]        run_cnt;

    always_comb begin
        err      = $signed({v_out[WIDTH-1], v_out}) - $signed({target[WIDTH-1], target});
        err_mag  = err[EW-1] ? $unsigned(-err) : $unsigned(err);
        in_band  = (err_mag <= {1'b0, tol});
        hit      = active && !pass && in_band && (run_cnt == HW'(HOLD - 1));
        pass_now = pass | hit;
    end

`ifdef TF_STEP_MON_OVERSHOOT_EN
    logic [EW-1:0] peak_mag;

    always_comb begin
        peak_mag = peak_err[EW-1] ? $unsigned(-peak_err) : $unsigned(peak_err);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            peak_err <= '0;
        end else if (active && (err_mag > peak_mag)) begin
            // Strict compare keeps the first occurrence on a magnitude tie.
            peak_err <= err;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            run_cnt       <= '0;
            pass          <= 1'b0;
            settle_cycles <= '0;
        end else if (active && !pass) begin
            if (hit) begin
                pass          <= 1'b1;
                // Index of the first sample of the qualifying run.
                settle_cycles <= t - CW'(HOLD - 1);
            end else begin
                run_cnt <= in_band ? run_cnt + HW'(1) : '0;
                if (finish) begin
                    settle_cycles <= CW'(TIMEOUT);
                end
            end
        end
    end

endmodule

// File: rtl/tf_step_monitor.sv
// Step-response monitor for msdsl filter models.
//
// On start it drives a latched step amplitude onto every filter input, then
// watches each filter output until it stays within +/-tol of its target for
// HOLD consecutive cycles, or until TIMEOUT DRIVE cycles have elapsed. Results
// (pass, settle_cycles) appear together with a one-cycle done pulse and are
// held until the next start or rst.
//
// Optional feature (macro TF_STEP_MON_OVERSHOOT_EN): adds peak_err, the signed
// error of largest magnitude per channel during DRIVE.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - begin a run (accepted in IDLE or DONE only)
//   amplitude       - signed step value for all channels
//   target          - N_CH signed targets, ch0 in LSBs
//   tol             - unsigned band half-width
//   v_out           - N_CH signed filter outputs
//   v_in            - N_CH signed filter inputs
//   busy            - high while driving the step
//   done            - one-cycle pulse at the end of a run
//   settle_cycles   - N_CH settle times, CW bits each
//   pass            - N_CH settled flags
//   peak_err        - (optional) N_CH signed peak errors, WIDTH+1 bits each
module tf_step_monitor
    import tf_step_mon_pkg::*;
#(
    parameter int unsigned WIDTH   = 18,
    parameter int unsigned N_CH    = 2,
    parameter int unsigned HOLD    = 8,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CW      = cnt_width(TIMEOUT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   amplitude,
    input  logic [N_CH*WIDTH-1:0]     target,
    input  logic [WIDTH-1:0]          tol,
    input  logic [N_CH*WIDTH-1:0]     v_out,
    output logic [N_CH*WIDTH-1:0]     v_in,
    output logic                      busy,
    output logic                      done,
    output logic [N_CH*CW-1:0]        settle_cycles,
    output logic [N_CH-1:0]           pass
`ifdef TF_STEP_MON_OVERSHOOT_EN
    ,
    output logic [N_CH*(WIDTH+1)-1:0] peak_err
`endif
);

    state_e                 state;
    logic [CW-1:0]          t;
    logic [N_CH*WIDTH-1:0]  target_q;
    logic [WIDTH-1:0]       tol_q;

    logic                   start_ok;
    logic                   active;
    logic                   last_cycle;
    logic                   finish;
    logic [N_CH-1:0]        pass_now;

    always_comb begin
        start_ok   = start && ((state == StIdle) || (state == StDone));
        active     = (state == StDrive);
        last_cycle = (t == CW'(TIMEOUT - 1));
        // pass_now includes latches made this cycle, so the final pass exits at once.
        finish     = active && ((&pass_now) || last_cycle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            t        <= '0;
            target_q <= '0;
            tol_q    <= '0;
            v_in     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state    <= StDrive;
                        t        <= '0;
                        target_q <= target;
                        tol_q    <= tol;
                        v_in     <= {N_CH{amplitude}};
                        busy     <= 1'b1;
                    end
                end
                StDrive: begin
                    if (finish) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        v_in  <= '0;
                    end else begin
                        t <= t + CW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        tf_settle_detect #(
            .WIDTH   (WIDTH),
            .HOLD    (HOLD),
            .TIMEOUT (TIMEOUT),
            .CW      (CW)
        ) u_detect (
            .clk           (clk),
            .rst           (rst),
            .clear         (start_ok),
            .active        (active),
            .finish        (finish),
            .t             (t),
            .v_out         (v_out[ch*WIDTH +: WIDTH]),
            .target        (target_q[ch*WIDTH +: WIDTH]),
            .tol           (tol_q),
            .pass_now      (pass_now[ch]),
            .pass          (pass[ch]),
            .settle_cycles (settle_cycles[ch*CW +: CW])
`ifdef TF_STEP_MON_OVERSHOOT_EN
            ,
            .peak_err      (peak_err[ch*(WIDTH+1) +: WIDTH+1])
`endif
        );
    end

endmodule

// File: tb/tb_tf_step_monitor.sv
// Self-checking bench for tf_step_monitor (N_CH=2, HOLD=8, TIMEOUT=64).
// Filter models (ideal 1-cycle delay, first-order low-pass, table playback)
// drive v_out; expected results come from a window-search reference model.
module tb_tf_step_monitor;

    localparam int unsigned WIDTH   = 18;
    localparam int unsigned N_CH    = 2;
    localparam int unsigned HOLD    = 8;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CW      = $clog2(TIMEOUT + 1);

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic signed [WIDTH-1:0]   amplitude;
    logic [N_CH*WIDTH-1:0]     target;
    logic [WIDTH-1:0]          tol;
    logic [N_CH*WIDTH-1:0]     v_out;
    logic [N_CH*WIDTH-1:0]     v_in;
    logic                      busy;
    logic                      done;
    logic [N_CH*CW-1:0]        settle_cycles;
    logic [N_CH-1:0]           pass;
`ifdef TF_STEP_MON_OVERSHOOT_EN
    logic [N_CH*(WIDTH+1)-1:0] peak_err;
`endif

    always #5 clk = ~clk;

    tf_step_monitor #(
        .WIDTH   (WIDTH),
        .N_CH    (N_CH),
        .HOLD    (HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .amplitude     (amplitude),
        .target        (target),
        .tol           (tol),
        .v_out         (v_out),
        .v_in          (v_in),
        .busy          (busy),
        .done          (done),
        .settle_cycles (settle_cycles),
        .pass          (pass)
`ifdef TF_STEP_MON_OVERSHOOT_EN
        ,
        .peak_err      (peak_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Filter models: 0 = ideal delay, 1 = y += (x-y)>>3, 2 = table playback by t.
    int   mode   [N_CH];
    int   vo_tab [N_CH][TIMEOUT];
    int   fy     [N_CH];
    int   tb_t = 0;
    logic go = 1'b0;

    function automatic int vin_of(input int c);
        return int'($signed(v_in[c*WIDTH +: WIDTH]));
    endfunction

    always @(posedge clk) begin
        tb_t <= go ? 0 : ((tb_t < int'(TIMEOUT) - 1) ? tb_t + 1 : tb_t);
        for (int c = 0; c < int'(N_CH); c++) begin
            fy[c] <= go ? 0 : ((mode[c] == 1) ? fy[c] + ((vin_of(c) - fy[c]) >>> 3) : vin_of(c));
        end
    end

    always_comb begin
        v_out = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            v_out[c*WIDTH +: WIDTH] = (mode[c] == 2) ? WIDTH'(vo_tab[c][tb_t]) : WIDTH'(fy[c]);
        end
    end

    // Run description and expected results.
    int amp_r;
    int tgt_r [N_CH];
    int tol_r;
    int exp_pass   [N_CH];
    int exp_settle [N_CH];
    int exp_peak   [N_CH];
    int exp_tfin;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: build each channel's output trace, then find the earliest
    // HOLD-long window fully inside the band.
    task automatic model();
        int vo [N_CH][TIMEOUT];
        int e  [N_CH];
        int y, mx, pk, er;
        bit all_ok, win_ok;
        for (int c = 0; c < int'(N_CH); c++) begin
            y = 0;
            for (int k = 0; k < int'(TIMEOUT); k++) begin
                if (mode[c] == 2) begin
                    vo[c][k] = vo_tab[c][k];
                end else begin
                    vo[c][k] = y;
                    y = (mode[c] == 1) ? y + ((amp_r - y) >>> 3) : amp_r;
                end
            end
            e[c] = -1;
            for (int s = 0; s + int'(HOLD) <= int'(TIMEOUT) && e[c] < 0; s++) begin
                win_ok = 1'b1;
                for (int k = s; k < s + int'(HOLD); k++) begin
                    if (iabs(vo[c][k] - tgt_r[c]) > tol_r) win_ok = 1'b0;
                end
                if (win_ok) e[c] = s + int'(HOLD) - 1;
            end
        end
        all_ok = 1'b1;
        mx = 0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (e[c] < 0) all_ok = 1'b0;
            else if (e[c] > mx) mx = e[c];
        end
        exp_tfin = all_ok ? mx : int'(TIMEOUT) - 1;
        for (int c = 0; c < int'(N_CH); c++) begin
            exp_pass[c]   = (e[c] >= 0 && e[c] <= exp_tfin) ? 1 : 0;
            exp_settle[c] = exp_pass[c] ? e[c] - int'(HOLD) + 1 : int'(TIMEOUT);
            pk = 0;
            for (int k = 0; k <= exp_tfin; k++) begin
                er = vo[c][k] - tgt_r[c];
                if (iabs(er) > iabs(pk)) pk = er;
            end
            exp_peak[c] = pk;
        end
    endtask

    task automatic check_results(input string tag);
        for (int c = 0; c < int'(N_CH); c++) begin
            check($sformatf("%s_pass%0d", tag, c), 64'(pass[c]), 64'(exp_pass[c]));
            check($sformatf("%s_settle%0d", tag, c), 64'(settle_cycles[c*CW +: CW]),
                  64'(exp_settle[c]));
`ifdef TF_STEP_MON_OVERSHOOT_EN
            check($sformatf("%s_peak%0d", tag, c), 64'(peak_err[c*(WIDTH+1) +: WIDTH+1]),
                  64'((WIDTH+1)'(exp_peak[c])));
`endif
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_vin"}, 64'(v_in), 64'(0));
        check({tag, "_pass"}, 64'(pass), 64'(0));
        check({tag, "_settle"}, 64'(settle_cycles), 64'(0));
`ifdef TF_STEP_MON_OVERSHOOT_EN
        check({tag, "_peak"}, 64'(peak_err), 64'(0));
`endif
    endtask

    task automatic run_case(input string name, input int disturb_at, input int abort_at);
        logic [N_CH*WIDTH-1:0] exp_vin;
        model();
        @(negedge clk);
        start     = 1'b1;
        go        = 1'b1;
        amplitude = WIDTH'(amp_r);
        for (int c = 0; c < int'(N_CH); c++) target[c*WIDTH +: WIDTH] = WIDTH'(tgt_r[c]);
        tol       = WIDTH'(tol_r);
        exp_vin   = {N_CH{WIDTH'(amp_r)}};
        @(negedge clk);
        start = 1'b0;
        go    = 1'b0;
        for (int k = 0; k <= exp_tfin; k++) begin
            if (k == 0) begin
                check({name, "_clr_pass"}, 64'(pass), 64'(0));
                check({name, "_clr_settle"}, 64'(settle_cycles), 64'(0));
            end
            check({name, "_busy"}, 64'(busy), 64'(1));
            check({name, "_done_low"}, 64'(done), 64'(0));
            check({name, "_vin"}, 64'(v_in), 64'(exp_vin));
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_state({name, "_abort"});
                @(negedge clk);
                check({name, "_abort_nodone"}, 64'(done), 64'(0));
                return;
            end
            if (k == disturb_at) begin
                start     = 1'b1;
                amplitude = WIDTH'(amp_r + 777);
                target    = ~target;
            end else if (k == disturb_at + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_done"}, 64'(done), 64'(1));
        check({name, "_busy_end"}, 64'(busy), 64'(0));
        check({name, "_vin_end"}, 64'(v_in), 64'(0));
        check_results({name, "_end"});
        @(negedge clk);
        check({name, "_done_pulse"}, 64'(done), 64'(0));
        check_results({name, "_hold"});
    endtask

    task automatic fill_table(input int c, input int val);
        for (int k = 0; k < int'(TIMEOUT); k++) vo_tab[c][k] = val;
    endtask

    task automatic gen_random_table(input int c, input int tgt, input int tl, input int p_in);
        int off;
        for (int k = 0; k < int'(TIMEOUT); k++) begin
            if (int'($urandom_range(0, 99)) < p_in) begin
                off = int'($urandom_range(0, 2 * tl)) - tl;
            end else begin
                off = tl + 1 + int'($urandom_range(0, 40));
                if ($urandom_range(0, 1) == 1) off = -off;
            end
            vo_tab[c][k] = tgt + off;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        amplitude = '0;
        target    = '0;
        tol       = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            mode[c] = 0;
            fy[c]   = 0;
            fill_table(c, 0);
        end
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("idle");

        // Ideal delay, exact match: settle 1, done after t=8.
        mode[0] = 0; mode[1] = 0;
        amp_r = 1000; tgt_r[0] = 1000; tgt_r[1] = 1000; tol_r = 0;
        run_case("ideal", -1, -1);
        check("ideal_tfin", 64'(exp_tfin), 64'(8));

        // First-order low-pass.
        mode[0] = 1; mode[1] = 1;
        amp_r = 4096; tgt_r[0] = 4096; tgt_r[1] = 4096; tol_r = 64;
        run_case("lowpass", -1, -1);

        // ch1 stuck at 0: timeout with settle = TIMEOUT.
        mode[0] = 0; mode[1] = 2; fill_table(1, 0);
        amp_r = 500; tgt_r[0] = 500; tgt_r[1] = 500; tol_r = 10;
        run_case("timeout", -1, -1);

        // HOLD-1 in-band samples, one excursion, then in band from t=8.
        mode[0] = 2; mode[1] = 0; fill_table(0, 2000); vo_tab[0][HOLD-1] = 2100;
        amp_r = 2000; tgt_r[0] = 2000; tgt_r[1] = 2000; tol_r = 5;
        run_case("broken", -1, -1);

        // Last channel passes on the timeout cycle itself.
        mode[0] = 0; mode[1] = 2; fill_table(1, 0);
        for (int k = int'(TIMEOUT - HOLD); k < int'(TIMEOUT); k++) vo_tab[1][k] = 300;
        amp_r = 300; tgt_r[0] = 300; tgt_r[1] = 300; tol_r = 3;
        run_case("edge_timeout", -1, -1);

        // Reset at t=20 aborts the run, then a clean ideal run.
        mode[0] = 0; mode[1] = 2; fill_table(1, 0);
        amp_r = 500; tgt_r[0] = 500; tgt_r[1] = 500; tol_r = 10;
        run_case("abort", -1, 20);
        mode[0] = 0; mode[1] = 0;
        amp_r = 1000; tgt_r[0] = 1000; tgt_r[1] = 1000; tol_r = 0;
        run_case("after_abort", -1, -1);

        // start and new amplitude/target during DRIVE are ignored.
        mode[0] = 0; mode[1] = 0;
        amp_r = 1000; tgt_r[0] = 1000; tgt_r[1] = 1000; tol_r = 0;
        run_case("disturb", 3, -1);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            amp_r = int'($urandom_range(0, 100000)) - 50000;
            tol_r = int'($urandom_range(0, 200));
            for (int c = 0; c < int'(N_CH); c++) begin
                mode[c] = int'($urandom_range(0, 2));
                if (mode[c] == 2) begin
                    tgt_r[c] = int'($urandom_range(0, 100000)) - 50000;
                    gen_random_table(c, tgt_r[c], tol_r, 92);
                end else begin
                    tgt_r[c] = amp_r + int'($urandom_range(0, 2 * tol_r)) - tol_r;
                end
            end
            run_case($sformatf("rand%0d", r), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
